// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the parallel-to-serial front stage of the pattern detector.
// Constants that the detector also depends on live here.
package bit_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // The detector's start state assumes this level on c while nothing is in flight.
    localparam logic IDLE_BIT = 1'b0;

endpackage

// File: rtl/bit_serializer.sv
// Loads WIDTH-bit words on load && ready and shifts them onto c, one bit per rising ck.
// Back-to-back words reload on the last-bit cycle, so the stream has no gap.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int   WIDTH     = DEFAULT_WIDTH,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = bit_serializer_pkg::IDLE_BIT
) (
    input  logic             ck,
    input  logic             rs_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             hold,
    output logic             ready,
    output logic             c,
    output logic             busy,
    output logic             last
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             c_q, c_d;
    logic             accept;

    // Handshake: a word transfers on the rising edge where load && ready are both high.
    // ready never depends on load, and din is only looked at on that edge.
    assign ready  = !hold && rs_n && (state_q == ST_IDLE || cnt_q == '0);
    assign accept = load && ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        c_d     = c_q;
        if (accept) begin
            state_d = ST_SHIFT;
            cnt_d   = CNT_LOAD;
            if (MSB_FIRST) begin
                c_d     = din[WIDTH-1];
                shreg_d = din << 1;
            end else begin
                c_d     = din[0];
                shreg_d = din >> 1;
            end
        end else if (!hold && state_q == ST_SHIFT) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
                if (MSB_FIRST) begin
                    c_d     = shreg_q[WIDTH-1];
                    shreg_d = shreg_q << 1;
                end else begin
                    c_d     = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                end
            end else begin
                state_d = ST_IDLE;
                c_d     = IDLE_BIT;
            end
        end
    end

    always_ff @(posedge ck or negedge rs_n) begin
        if (!rs_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            c_q     <= IDLE_BIT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            c_q     <= c_d;
        end
    end

    // Status comes straight from registered state, so the detector sees clean levels.
    assign c    = c_q;
    assign busy = (state_q == ST_SHIFT);
    assign last = (state_q == ST_SHIFT) && (cnt_q == '0);

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: an MSB-first and an LSB-first instance share clock,
// reset and hold; drivers push hand-computed bit streams, a monitor pops them as bits appear.
module tb_bit_serializer;

  logic       ck;
  logic       rs_n;
  logic       hold;
  logic       load_h, load_l;
  logic [7:0] din_h, din_l;
  logic       ready_h, ready_l;
  logic       c_h, c_l;
  logic       busy_h, busy_l;
  logic       last_h, last_l;

  logic [1:0] exp_q0[$];  // {last, c} expected for the MSB-first instance
  logic [1:0] exp_q1[$];  // {last, c} expected for the LSB-first instance
  logic [1:0] last_exp[2];

  int n_checks;
  int n_errors;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .ck(ck), .rs_n(rs_n), .load(load_h), .din(din_h), .hold(hold),
    .ready(ready_h), .c(c_h), .busy(busy_h), .last(last_h)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .ck(ck), .rs_n(rs_n), .load(load_l), .din(din_l), .hold(hold),
    .ready(ready_l), .c(c_l), .busy(busy_l), .last(last_l)
  );

  // clock
  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // monitor: pops one expected bit per edge on which a DUT shows a word bit
  initial begin
    logic hold_s;
    logic cb, bb, lb;
    logic [1:0] e;
    last_exp[0] = 2'b00;
    last_exp[1] = 2'b00;
    forever begin
      @(posedge ck);
      hold_s = hold;
      #2;
      for (int id = 0; id < 2; id++) begin
        cb = (id == 0) ? c_h : c_l;
        bb = (id == 0) ? busy_h : busy_l;
        lb = (id == 0) ? last_h : last_l;
        if (bb) begin
          if (hold_s) begin
            chk("frozen_c", {31'd0, cb}, {31'd0, last_exp[id][0]});
            chk("frozen_last", {31'd0, lb}, {31'd0, last_exp[id][1]});
          end else if ((id == 0 && exp_q0.size() == 0) || (id == 1 && exp_q1.size() == 0)) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_bit dut%0d at %0t: got c=%0b expected no word in flight", id, $time, cb);
          end else begin
            e = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            last_exp[id] = e;
            chk(id == 0 ? "c_msb" : "c_lsb", {31'd0, cb}, {31'd0, e[0]});
            chk(id == 0 ? "last_msb" : "last_lsb", {31'd0, lb}, {31'd0, e[1]});
          end
        end else begin
          chk("idle_c", {31'd0, cb}, 32'd0);
          chk("idle_last", {31'd0, lb}, 32'd0);
        end
      end
    end
  end

  task automatic push_bits(input int id, input int nbits, input logic [15:0] bits);
    for (int i = nbits - 1; i >= 0; i--) begin
      if (id == 0) exp_q0.push_back({(i % 8) == 0, bits[i]});
      else         exp_q1.push_back({(i % 8) == 0, bits[i]});
    end
  endtask

  // Hold load high across n words; din is scrambled on the cycles it must be ignored.
  task automatic send_stream(input int id, input int n, input logic [7:0] w0,
                             input logic [7:0] w1, input logic [15:0] bits);
    for (int k = 0; k < n; k++) begin
      @(negedge ck);
      if (id == 0) begin din_h = (k == 0) ? w0 : w1; load_h = 1'b1; end
      else         begin din_l = (k == 0) ? w0 : w1; load_l = 1'b1; end
      if (k == 0) push_bits(id, n * 8, bits);
      chk("ready_accept", {31'd0, (id == 0) ? ready_h : ready_l}, 32'd1);
      for (int j = 1; j < 8; j++) begin
        @(negedge ck);
        if (id == 0) din_h = 8'($urandom_range(0, 255));
        else         din_l = 8'($urandom_range(0, 255));
        chk("ready_mid", {31'd0, (id == 0) ? ready_h : ready_l}, 32'd0);
      end
    end
    @(negedge ck);
    if (id == 0) load_h = 1'b0; else load_l = 1'b0;
    chk("ready_last", {31'd0, (id == 0) ? ready_h : ready_l}, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge ck);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rs_n   = 1'b0;
    hold   = 1'b0;
    load_h = 1'b0;
    load_l = 1'b0;
    din_h  = 8'h00;
    din_l  = 8'h00;

    // reset state
    idle(2);
    chk("rst_ready", {31'd0, ready_h}, 32'd0);
    chk("rst_c", {31'd0, c_h}, 32'd0);
    chk("rst_busy", {31'd0, busy_h}, 32'd0);
    rs_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge ck);
      chk("idle_ready", {31'd0, ready_h}, 32'd1);
      chk("idle_busy", {31'd0, busy_h}, 32'd0);
    end

    // single word 0x36, MSB first
    send_stream(0, 1, 8'b00110110, 8'h00, 16'b00110110);
    idle(3);

    // gapless pair 0xC3, 0x5A
    send_stream(0, 2, 8'hC3, 8'h5A, 16'b1100001101011010);
    idle(3);

    // hold for three edges while bit 3 of 0xF0 is on c
    @(negedge ck);
    din_h = 8'hF0; load_h = 1'b1;
    push_bits(0, 8, 16'b11110000);
    @(negedge ck);
    load_h = 1'b0;
    idle(2);
    hold = 1'b1;
    load_h = 1'b1;
    #1;
    chk("hold_ready", {31'd0, ready_h}, 32'd0);
    idle(2);
    @(negedge ck);
    hold = 1'b0;
    load_h = 1'b0;
    idle(8);

    // reset mid-word after bit 4 of 0xFF
    @(negedge ck);
    din_h = 8'hFF; load_h = 1'b1;
    push_bits(0, 8, 16'b11111111);
    @(negedge ck);
    load_h = 1'b0;
    idle(3);
    rs_n = 1'b0;
    exp_q0.delete();
    #1;
    chk("midrst_c", {31'd0, c_h}, 32'd0);
    chk("midrst_busy", {31'd0, busy_h}, 32'd0);
    chk("midrst_ready", {31'd0, ready_h}, 32'd0);
    idle(2);
    rs_n = 1'b1;
    idle(2);
    send_stream(0, 1, 8'h81, 8'h00, 16'b10000001);
    idle(3);

    // LSB-first instance
    send_stream(1, 1, 8'h01, 8'h00, 16'b10000000);
    idle(4);

    chk("drain_msb", exp_q0.size(), 32'd0);
    chk("drain_lsb", exp_q1.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial front stage feeding the serial pattern detector's single-bit input `c`.
- Accepts WIDTH-bit words through a load/ready handshake and shifts them out one bit per `ck` rising edge.
- Back-to-back words stream with no idle gap.
- The detector samples `c` on the falling edge of `ck`, so `c` changing on the rising edge gives it half a cycle of setup.

Parameters:
- WIDTH, 8, word length in bits (legal range 2..32).
- MSB_FIRST, 1, 1 = transmit din[WIDTH-1] first; 0 = transmit din[0] first.
- IDLE_BIT, 0, value driven on `c` when no word is in flight.

Ports:
- ck  input  1  clock; all state updates on the rising edge.
- rs_n  input  1  asynchronous active-low reset.
- load  input  1  word-valid strobe from the producer.
- din  input  WIDTH  word to serialize; sampled only on an accept edge.
- hold  input  1  stall request; freezes all state while high.
- ready  output  1  block can accept a word on this edge.
- c  output  1  registered serial bit to the detector.
- busy  output  1  high while a word bit is on `c`.
- last  output  1  high while the final bit of a word is on `c`.

Behaviour:
- Clock and reset:
  - One clock, `ck`; all state updates on the rising edge.
  - Reset `rs_n` is asynchronous and active-low.
- Reset (`rs_n` = 0, asynchronous):
  - state = IDLE, shreg = 0, cnt = 0.
  - c = IDLE_BIT, busy = 0, last = 0.
  - ready = 0 while `rs_n` is low; ready = 1 from the first cycle after release.
- States: IDLE and SHIFT. `cnt` counts bits remaining after the current bit, width clog2(WIDTH).
- ready (combinational) = !hold && rs_n && (state == IDLE || (state == SHIFT && cnt == 0)).
- Accept:
  - Occurs on a rising edge with load && ready.
  - c <= first bit of din, selected by MSB_FIRST.
  - shreg <= the remaining bits, shifted into place.
  - cnt <= WIDTH-1; state <= SHIFT.
- Latency: the first bit appears on `c` one edge after accept. A word occupies `c` for exactly WIDTH cycles.
- SHIFT with cnt > 0 (and no hold):
  - c <= next bit; shreg shifts by one; cnt <= cnt-1.
  - `load` is ignored.
- SHIFT with cnt == 0:
  - If load: immediate reload per the accept rule, giving a gapless stream.
  - Otherwise: c <= IDLE_BIT; state <= IDLE.
- IDLE without load: c holds IDLE_BIT.
- busy = (state == SHIFT). last = (state == SHIFT && cnt == 0). Both are derived from registered state, so they are glitch-free.
- hold = 1:
  - state, cnt, shreg and c are frozen; ready = 0; load is ignored.
  - Release resumes exactly where the stream stopped; no bit is dropped or duplicated.
- din changing while not accepting has no effect.
- Reset mid-word: the word is discarded immediately and c returns to IDLE_BIT asynchronously. The word is not resumed.
- load held high continuously: every WIDTH cycles a new word is accepted, on the cycle where last = 1.

Decomposition:
- Shared package:
  - State encoding: ST_IDLE = 1'b0, ST_SHIFT = 1'b1.
  - Default WIDTH.
  - IDLE_BIT constant, shared with the detector's start-state assumption.
- No sub-module; the shift register and counter are kept inline in a single module.

Test Plan:
- Reset release, no load -> ready = 1, c = 0, busy = 0 for 10 cycles.
- Single word din = 8'b00110110, MSB_FIRST = 1, one-cycle load -> c = 0,0,1,1,0,1,1,0 on the following 8 edges; last high only on the 8th; then IDLE with c = 0.
- load held high with words 8'hC3 then 8'h5A -> 16 consecutive bits 11000011 01011010, no gap; ready high only on the last-bit cycles.
- hold asserted for 3 cycles after the 3rd bit of 8'hF0 -> c frozen at 1 for those cycles; remaining bits 1,0,0,0,0 follow unchanged.
- rs_n pulsed low mid-word (after bit 4 of 8'hFF) -> c = 0 immediately; next load of 8'h81 transmits 1,0,0,0,0,0,0,1 cleanly.
- MSB_FIRST = 0, din = 8'h01 -> c = 1,0,0,0,0,0,0,0.
